// File: rtl/sprite_renderer.sv
// Raster-scan sprite renderer: walks every screen pixel, fetches sprite colour from a 1-cycle ROM, emits pixels over valid/ready.
// Optional colour-key transparency enabled by defining SPRITE_RENDERER_TRANSPARENCY_EN.
module sprite_renderer #(
  parameter int unsigned WIDTH              = 240,
  parameter int unsigned HEIGHT             = 320,
  parameter int unsigned SPRITE_W           = 16,
  parameter int unsigned SPRITE_H           = 16,
  parameter logic [15:0] BG_COLOUR          = 16'h0000,
  parameter logic [15:0] TRANSPARENT_COLOUR = 16'hF81F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frameStart,
  input  logic [7:0]  xSprite,
  input  logic [8:0]  ySprite,
  input  logic [3:0]  spriteId,
  output logic [11:0] romAddress,
  input  logic [15:0] romData,
  output logic [7:0]  pixelX,
  output logic [8:0]  pixelY,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic        busy,
  output logic        frameDone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [7:0] LP_X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0] LP_Y_LAST = 9'(HEIGHT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_px;
  logic [8:0]  r_py;
  logic [7:0]  r_xs;
  logic [8:0]  r_ys;
  logic [3:0]  r_id;
  logic        r_inside;
  logic [11:0] r_rom_addr;
  logic [7:0]  r_pixel_x;
  logic [8:0]  r_pixel_y;
  logic [15:0] r_pixel_data;
  logic        r_pixel_write;
  logic        r_busy;
  logic        r_frame_done;

  logic [9:0]  w_x_end;
  logic [9:0]  w_y_end;
  logic        w_inside;
  logic [3:0]  w_col;
  logic [3:0]  w_row;
  logic [11:0] w_addr;
  logic        w_use_rom;

  // 10-bit sums so a sprite near the right/bottom edge clips instead of wrapping
  assign w_x_end  = {2'b00, r_xs} + 10'(SPRITE_W);
  assign w_y_end  = {1'b0, r_ys} + 10'(SPRITE_H);
  assign w_inside = (r_px >= r_xs) && ({2'b00, r_px} < w_x_end) &&
                    (r_py >= r_ys) && ({1'b0, r_py} < w_y_end);

  // Low nibble of the offset only depends on low nibbles of the operands
  assign w_col  = r_px[3:0] - r_xs[3:0];
  assign w_row  = r_py[3:0] - r_ys[3:0];
  assign w_addr = {r_id, w_row, w_col};

  // Address is presented during ADDR so the 1-cycle ROM answers in DATA; otherwise hold last value
  assign romAddress = ((r_state == S_ADDR) && w_inside) ? w_addr : r_rom_addr;

`ifdef SPRITE_RENDERER_TRANSPARENCY_EN
  assign w_use_rom = r_inside && (romData != TRANSPARENT_COLOUR);
`else
  assign w_use_rom = r_inside;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_px          <= '0;
      r_py          <= '0;
      r_xs          <= '0;
      r_ys          <= '0;
      r_id          <= '0;
      r_inside      <= 1'b0;
      r_rom_addr    <= '0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_pixel_data  <= '0;
      r_pixel_write <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frameStart) begin
            r_xs    <= xSprite;
            r_ys    <= ySprite;
            r_id    <= spriteId;
            r_px    <= '0;
            r_py    <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_inside <= w_inside;
          if (w_inside) r_rom_addr <= w_addr;
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_pixel_data  <= w_use_rom ? romData : BG_COLOUR;
          r_pixel_x     <= r_px;
          r_pixel_y     <= r_py;
          r_pixel_write <= 1'b1;
          r_state       <= S_WRITE;
        end
        S_WRITE: begin
          if (pixelReady) begin
            r_pixel_write <= 1'b0;
            if (r_px == LP_X_LAST) begin
              r_px <= '0;
              if (r_py == LP_Y_LAST) begin
                r_py         <= '0;
                r_frame_done <= 1'b1;
                r_busy       <= 1'b0;
                r_state      <= S_IDLE;
              end else begin
                r_py    <= r_py + 9'd1;
                r_state <= S_ADDR;
              end
            end else begin
              r_px    <= r_px + 8'd1;
              r_state <= S_ADDR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixelX     = r_pixel_x;
  assign pixelY     = r_pixel_y;
  assign pixelData  = r_pixel_data;
  assign pixelWrite = r_pixel_write;
  assign busy       = r_busy;
  assign frameDone  = r_frame_done;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer on a reduced 40x40 screen; ROM model echoes the address or returns the key colour.
module tb_sprite_renderer;

  localparam int W     = 40;
  localparam int H     = 40;
  localparam int LIMIT = 30000;
`ifdef SPRITE_RENDERER_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        frameStart;
  logic [7:0]  xSprite;
  logic [8:0]  ySprite;
  logic [3:0]  spriteId;
  logic [11:0] romAddress;
  logic [15:0] romData;
  logic [7:0]  pixelX;
  logic [8:0]  pixelY;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic        busy;
  logic        frameDone;

  sprite_renderer #(
    .WIDTH(W),
    .HEIGHT(H),
    .SPRITE_W(16),
    .SPRITE_H(16),
    .BG_COLOUR(16'h0000),
    .TRANSPARENT_COLOUR(16'hF81F)
  ) dut (
    .clock(clock), .reset(reset), .frameStart(frameStart),
    .xSprite(xSprite), .ySprite(ySprite), .spriteId(spriteId),
    .romAddress(romAddress), .romData(romData),
    .pixelX(pixelX), .pixelY(pixelY), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .busy(busy), .frameDone(frameDone)
  );

  typedef struct {
    int          x;
    int          y;
    logic [15:0] d;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   xfer_count = 0;
  int   done_count = 0;
  bit   prev_last = 1'b0;
  bit   rom_key = 1'b0;
  bit   rand_ready = 1'b0;
  bit   ready_level = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM, 1-cycle latency
  always @(posedge clock) romData <= rom_key ? 16'hF81F : {4'h0, romAddress};

  always @(posedge clock) begin
    #1;
    pixelReady = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented pixel against the queue head, pop on transfer
  always @(negedge clock) begin
    if (!reset) begin
      if (frameDone) begin
        done_count++;
        chk("frameDone_after_last_xfer", prev_last, 64'(frameDone), 64'(prev_last));
        chk("busy_low_at_frameDone", busy == 1'b0, 64'(busy), 0);
      end
      prev_last = 1'b0;
      if (pixelWrite) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1'b0, {pixelX, pixelY}, 0);
        end else begin
          pix_t e;
          e = exp_q[0];
          checks++;
          if (int'(pixelX) != e.x || int'(pixelY) != e.y || pixelData != e.d) begin
            failures++;
            $display("FAIL pixel actual=(%0d,%0d,%h) expected=(%0d,%0d,%h) ready=%0b",
                     pixelX, pixelY, pixelData, e.x, e.y, e.d, pixelReady);
          end
          if (pixelReady) begin
            void'(exp_q.pop_front());
            xfer_count++;
            prev_last = (e.x == W - 1) && (e.y == H - 1);
          end
        end
      end
    end else begin
      prev_last = 1'b0;
    end
  end

  task automatic push_frame(input int xs, input int ys, input int id);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pix_t p;
        p.x = x;
        p.y = y;
        p.d = 16'h0000;
        if (x >= xs && x < xs + 16 && y >= ys && y < ys + 16) begin
          if (rom_key) p.d = TRANSP ? 16'h0000 : 16'hF81F;
          else         p.d = {4'h0, 4'(id), 4'(y - ys), 4'(x - xs)};
        end
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic start_frame(input int xs, input int ys, input int id);
    @(posedge clock); #1;
    xSprite  = 8'(xs);
    ySprite  = 9'(ys);
    spriteId = 4'(id);
    xfer_count = 0;
    push_frame(xs, ys, id);
    frameStart = 1'b1;
    @(posedge clock); #1;
    frameStart = 1'b0;
    chk("busy_after_start", busy == 1'b1, 64'(busy), 1);
    chk("write_low_cycle1", pixelWrite == 1'b0, 64'(pixelWrite), 0);
    @(posedge clock); #1;
    chk("write_low_cycle2", pixelWrite == 1'b0, 64'(pixelWrite), 0);
    @(posedge clock); #1;
    chk("write_high_cycle3", pixelWrite == 1'b1, 64'(pixelWrite), 1);
  endtask

  task automatic wait_done();
    int prev;
    int n;
    prev = done_count;
    n = 0;
    while (done_count == prev && n < LIMIT) begin
      @(posedge clock);
      n++;
    end
    if (done_count == prev) chk("frameDone_timeout", 1'b0, n, LIMIT);
    repeat (4) @(posedge clock);
    #1;
    chk("single_frameDone", done_count == prev + 1, done_count, prev + 1);
    chk("idle_after_frame", busy == 1'b0, 64'(busy), 0);
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    chk("xfer_count", xfer_count == W * H, xfer_count, W * H);
  endtask

  initial begin
    reset = 1'b1;
    frameStart = 1'b0;
    xSprite = '0;
    ySprite = '0;
    spriteId = '0;
    pixelReady = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_romAddress", romAddress == 12'h000, romAddress, 0);
    chk("reset_pixelX", pixelX == 8'd0, pixelX, 0);
    chk("reset_pixelY", pixelY == 9'd0, pixelY, 0);
    chk("reset_pixelData", pixelData == 16'h0000, pixelData, 0);
    chk("reset_pixelWrite", pixelWrite == 1'b0, 64'(pixelWrite), 0);
    chk("reset_busy", busy == 1'b0, 64'(busy), 0);
    chk("reset_frameDone", frameDone == 1'b0, 64'(frameDone), 0);
    reset = 1'b0;

    // Basic placement: (10,20)->300, (25,35)->3FF, (9,20)/(26,20) background
    start_frame(10, 20, 3);
    wait_done();

    // Right/bottom clip, no wrap
    start_frame(W - 8, H - 8, 5);
    wait_done();

    // Backpressure
    rand_ready = 1'b1;
    start_frame(7, 3, 9);
    wait_done();
    rand_ready = 1'b0;

    // Mid-frame strobe with a new position must be ignored
    start_frame(10, 20, 3);
    repeat (300) @(posedge clock);
    #1;
    xSprite = 8'd100;
    frameStart = 1'b1;
    @(posedge clock); #1;
    frameStart = 1'b0;
    wait_done();

    // Sprite fully off-screen to the right
    start_frame(200, 0, 1);
    wait_done();

    // Key colour everywhere
    rom_key = 1'b1;
    start_frame(12, 12, 2);
    wait_done();
    rom_key = 1'b0;

    // Reset while stalled in WRITE
    start_frame(10, 20, 3);
    repeat (150) @(posedge clock);
    #1;
    ready_level = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    chk("stalled_before_reset", pixelWrite == 1'b1, 64'(pixelWrite), 1);
    reset = 1'b1;
    #1;
    chk("midreset_pixelWrite", pixelWrite == 1'b0, 64'(pixelWrite), 0);
    chk("midreset_busy", busy == 1'b0, 64'(busy), 0);
    chk("midreset_pixelX", pixelX == 8'd0, pixelX, 0);
    chk("midreset_pixelY", pixelY == 9'd0, pixelY, 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    ready_level = 1'b1;
    start_frame(30, 5, 4);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
